// File: rtl/elbeth_demux_1_to_2.sv
// 1-to-2 word demux: one private FIFO per consumer, routed per word by bit_select, 1-cycle latency.
// Backpressure: in_ready drops only when the selected FIFO is full or flush is high, so a stalled consumer never blocks the other side.

module elbeth_demux_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_flush,
  input  logic         i_push_vld,
  input  logic [W-1:0] i_push_dat,
  input  logic         i_pop_rdy,
  output logic         o_full,
  output logic         o_vld,
  output logic [W-1:0] o_dat
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_pop;

  assign o_vld  = (r_count != '0);
  assign o_full = (r_count == FULL_CNT);
  assign o_dat  = o_vld ? r_mem[r_rd_ptr] : '0;
  // A pop requested during flush is discarded along with everything else.
  assign w_pop  = o_vld & i_pop_rdy & ~i_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push_vld) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)      r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push_vld, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is left unreset; o_dat is masked while empty.
  always_ff @(posedge clk) begin
    if (i_push_vld) r_mem[r_wr_ptr] <= i_push_dat;
  end
endmodule

module elbeth_demux_1_to_2 #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] demux_in,
  input  logic                  in_valid,
  input  logic                  bit_select,
  output logic                  in_ready,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] out_1_data,
  output logic                  out_1_valid,
  input  logic                  out_1_ready,
  output logic [DATA_WIDTH-1:0] out_2_data,
  output logic                  out_2_valid,
  input  logic                  out_2_ready
);
  logic w_full_1;
  logic w_full_2;
  logic w_push_1;
  logic w_push_2;

  // Fullness is sampled before any same-cycle pop: no pass-through into a full FIFO.
  assign in_ready = ~flush & (bit_select ? ~w_full_2 : ~w_full_1);
  assign w_push_1 = in_valid & in_ready & ~bit_select;
  assign w_push_2 = in_valid & in_ready &  bit_select;

  elbeth_demux_fifo #(.W(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo_1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_flush    (flush),
    .i_push_vld (w_push_1),
    .i_push_dat (demux_in),
    .i_pop_rdy  (out_1_ready),
    .o_full     (w_full_1),
    .o_vld      (out_1_valid),
    .o_dat      (out_1_data)
  );

  elbeth_demux_fifo #(.W(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo_2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_flush    (flush),
    .i_push_vld (w_push_2),
    .i_push_dat (demux_in),
    .i_pop_rdy  (out_2_ready),
    .o_full     (w_full_2),
    .o_vld      (out_2_valid),
    .o_dat      (out_2_data)
  );
endmodule
